arm_mc_controller: RTL and testbench

- Multicycle control unit for the ARM core; the next-generation replacement for the single-cycle controller.
- A state machine sequences each instruction over 3-5 cycles. This lets one shared memory port carry both instruction and data traffic.
- Adds a valid/ready memory handshake with stall support, a registered NZCV flags register and full condition-code evaluation.
- Sits beside the multicycle datapath and drives its IR, PC, mux-select and write-enable strobes.

---
 rtl/arm_mc_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// states over one shared memory port, with a valid/ready handshake and a registered NZCV file.
module arm_mc_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit COND_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        Shifted,
    output logic [3:0]  Flags,
    output logic        undef
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        EXECR  = 4'd3,
        EXECI  = 4'd4,
        ALUWB  = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  flags_r;
    logic        cond_ex_r;
    logic        cond_ex_s;
    logic        ready_s;
    logic [3:0]  cond_s;
    logic [1:0]  op_s;
    logic [5:0]  funct_s;
    logic [3:0]  cmd_s;
    logic        s_bit_s;
    logic        rd_pc_s;
    logic [1:0]  alu_ctrl_s;
    logic        shifted_s;
    logic        cmd_valid_s;
    logic        is_cmp_s;
    logic        nz_only_s;
    logic        flag_we_s;
    logic        instr_unused_s;

    // Odd condition codes are the negation of the even code below them; 1111 negates AL.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic base;
        {n, z, c, v} = nzcv;
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = ~(n ^ v);
            3'b110:  base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    assign cond_s         = Instr[19:16];
    assign op_s           = Instr[15:14];
    assign funct_s        = Instr[13:8];
    assign cmd_s          = funct_s[4:1];
    assign s_bit_s        = funct_s[0];
    assign rd_pc_s        = (Instr[3:0] == 4'd15);
    assign instr_unused_s = ^Instr[7:4];

    assign ready_s   = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign cond_ex_s = COND_EN ? cond_eval(cond_s, flags_r) : 1'b1;
    assign Flags     = flags_r;
    assign ImmSrc    = op_s;
    assign RegSrc    = {(op_s == 2'b01), (op_s == 2'b10)};

    // Data-processing command decode: ALU op, MOV shifter select, CMP and NZ-only flag update.
    always_comb begin
        alu_ctrl_s  = 2'b00;
        shifted_s   = 1'b0;
        cmd_valid_s = 1'b1;
        is_cmp_s    = 1'b0;
        nz_only_s   = 1'b0;
        case (cmd_s)
            4'b0100: alu_ctrl_s = 2'b00;
            4'b0010: alu_ctrl_s = 2'b01;
            4'b0000: begin alu_ctrl_s = 2'b10; nz_only_s = 1'b1; end
            4'b1100: begin alu_ctrl_s = 2'b11; nz_only_s = 1'b1; end
            4'b1010: begin alu_ctrl_s = 2'b01; is_cmp_s  = 1'b1; end
            4'b1101: begin shifted_s  = 1'b1;  nz_only_s = 1'b1; end
            default: cmd_valid_s = 1'b0;
        endcase
    end

    assign flag_we_s = ((state_r == EXECR) || (state_r == EXECI)) && (s_bit_s || is_cmp_s) && cond_ex_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Condition is judged once in DECODE so an S-form cannot veto its own writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            cond_ex_r <= 1'b0;
        end else if (state_r == DECODE) begin
            cond_ex_r <= cond_ex_s;
        end else begin
            cond_ex_r <= cond_ex_r;
        end
    end

    // NZCV register; logical ops keep the previous C and V.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (flag_we_s) begin
            if (nz_only_s) begin
                flags_r <= {ALUFlags[3:2], flags_r[1:0]};
            end else begin
                flags_r <= ALUFlags;
            end
        end else begin
            flags_r <= flags_r;
        end
    end

    // Next-state and strobe generation; every strobe is forced low while reset is high.
    always_comb begin
        state_next_s = state_r;
        mem_req      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        AdrSrc       = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ALUControl   = 2'b00;
        Shifted      = 1'b0;
        undef        = 1'b0;
        if (reset) begin
            state_next_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    mem_req      = 1'b1;
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'b10;
                    ResultSrc    = 2'b10;
                    IRWrite      = ready_s;
                    PCWrite      = ready_s;
                    state_next_s = ready_s ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    case (op_s)
                        2'b00: begin
                            if (!cmd_valid_s) begin
                                undef        = 1'b1;
                                state_next_s = FETCH;
                            end else if (funct_s[5]) begin
                                state_next_s = EXECI;
                            end else begin
                                state_next_s = EXECR;
                            end
                        end
                        2'b01:   state_next_s = MEMADR;
                        2'b10:   state_next_s = BRANCH;
                        default: begin
                            undef        = 1'b1;
                            state_next_s = FETCH;
                        end
                    endcase
                end
                EXECR: begin
                    ALUSrcB      = 2'b00;
                    ALUControl   = alu_ctrl_s;
                    Shifted      = shifted_s;
                    state_next_s = ALUWB;
                end
                EXECI: begin
                    ALUSrcB      = 2'b01;
                    ALUControl   = alu_ctrl_s;
                    Shifted      = shifted_s;
                    state_next_s = ALUWB;
                end
                MEMADR: begin
                    ALUSrcB      = 2'b01;
                    state_next_s = funct_s[0] ? MEMRD : MEMWR;
                end
                ALUWB: begin
                    RegWrite     = cond_ex_r & ~is_cmp_s & ~rd_pc_s;
                    PCWrite      = cond_ex_r & rd_pc_s;
                    state_next_s = FETCH;
                end
                MEMRD: begin
                    mem_req      = 1'b1;
                    AdrSrc       = 1'b1;
                    state_next_s = ready_s ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    ResultSrc    = 2'b01;
                    RegWrite     = cond_ex_r & ~rd_pc_s;
                    PCWrite      = cond_ex_r & rd_pc_s;
                    state_next_s = FETCH;
                end
                MEMWR: begin
                    AdrSrc = 1'b1;
                    if (cond_ex_r) begin
                        mem_req      = 1'b1;
                        MemWrite     = 1'b1;
                        state_next_s = ready_s ? FETCH : MEMWR;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                BRANCH: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'b01;
                    ResultSrc    = 2'b10;
                    PCWrite      = cond_ex_r;
                    state_next_s = FETCH;
                end
                default: state_next_s = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: per-instruction expectations from a behavioural
// model are queued by the driver and compared by an independent output monitor.
`timescale 1ns/1ps
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        mem_req, MemWrite, IRWrite, AdrSrc, PCWrite, RegWrite, ALUSrcA, Shifted, undef;
    logic [1:0]  ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  Flags;

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .Shifted(Shifted), .Flags(Flags), .undef(undef)
    );

    typedef struct {
        logic [19:0] ins;
        logic [3:0]  af;
        int          fw;
        int          mw;
        bit          rst_mid;
    } stim_t;

    typedef struct {
        int         cycles;
        int         irw;
        int         pcw_fetch;
        int         regw;
        int         pcw_extra;
        int         memw;
        int         dreq;
        int         undefs;
        bit         has_exec;
        logic [1:0] alu;
        bit         shifted;
        logic [3:0] flags;
        logic [1:0] imm;
        logic [1:0] rsrc;
    } rec_t;

    stim_t      stim_q[$];
    rec_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         inst_idx = 0;
    logic [3:0] mflags = 4'b0000;
    bit         drv_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (instr %0d): actual %0h required %0h", name, inst_idx, act, req);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural model of one instruction: cycle count, strobe totals and resulting flags.
    function automatic rec_t model_instr(input logic [19:0] ins, input logic [3:0] af, input int fw, input int mw);
        rec_t r;
        logic [3:0] cond, cmd, rd;
        logic [1:0] op;
        logic [5:0] f;
        bit pass, legal, logical, cmp;
        cond = ins[19:16]; op = ins[15:14]; f = ins[13:8]; rd = ins[3:0]; cmd = f[4:1];
        pass = cond_ok(cond, mflags);
        r = '{default: 0};
        r.irw = 1; r.pcw_fetch = 1; r.imm = op; r.rsrc = {op == 2'b01, op == 2'b10};
        case (op)
            2'b00: begin
                legal = 1; logical = 0; cmp = 0;
                case (cmd)
                    4'b0100: r.alu = 2'd0;
                    4'b0010: r.alu = 2'd1;
                    4'b0000: begin r.alu = 2'd2; logical = 1; end
                    4'b1100: begin r.alu = 2'd3; logical = 1; end
                    4'b1010: begin r.alu = 2'd1; cmp = 1; end
                    4'b1101: begin r.alu = 2'd0; r.shifted = 1; logical = 1; end
                    default: legal = 0;
                endcase
                if (!legal) begin
                    r.cycles = 2 + fw; r.undefs = 1; r.alu = 2'd0; r.shifted = 0;
                end else begin
                    r.cycles = 4 + fw; r.has_exec = 1;
                    r.regw = int'(pass && !cmp && rd != 4'd15);
                    r.pcw_extra = int'(pass && rd == 4'd15);
                    if (pass && (f[0] || cmp)) mflags = logical ? {af[3:2], mflags[1:0]} : af;
                end
            end
            2'b01: begin
                r.has_exec = 1; r.alu = 2'd0;
                if (f[0]) begin
                    r.cycles = 5 + fw + mw; r.dreq = mw + 1;
                    r.regw = int'(pass && rd != 4'd15);
                    r.pcw_extra = int'(pass && rd == 4'd15);
                end else if (pass) begin
                    r.cycles = 4 + fw + mw; r.dreq = mw + 1; r.memw = mw + 1;
                end else begin
                    r.cycles = 4 + fw;
                end
            end
            2'b10: begin
                r.cycles = 3 + fw; r.pcw_extra = int'(pass);
            end
            default: begin
                r.cycles = 2 + fw; r.undefs = 1;
            end
        endcase
        r.flags = mflags;
        return r;
    endfunction

    function automatic logic [3:0] pick_cmd(input int k);
        case (k)
            0: return 4'b0100;
            1: return 4'b0010;
            2: return 4'b0000;
            3: return 4'b1100;
            4: return 4'b1010;
            default: return 4'b1101;
        endcase
    endfunction

    function automatic logic [19:0] rand_ins();
        logic [3:0] cond, rd;
        logic [1:0] op;
        logic [5:0] f;
        cond = ($urandom_range(2, 0) == 0) ? 4'hE : 4'($urandom_range(15, 0));
        op   = ($urandom_range(9, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
        f    = 6'($urandom_range(63, 0));
        if (op == 2'b00 && $urandom_range(7, 0) != 0) f[4:1] = pick_cmd(int'($urandom_range(5, 0)));
        rd   = ($urandom_range(5, 0) == 0) ? 4'hF : 4'($urandom_range(15, 0));
        return {cond, op, f, 4'($urandom_range(15, 0)), rd};
    endfunction

    task automatic add_stim(input logic [19:0] ins, input logic [3:0] af, input int fw, input int mw, input bit rm);
        stim_t s;
        s.ins = ins; s.af = af; s.fw = fw; s.mw = mw; s.rst_mid = rm;
        stim_q.push_back(s);
    endtask

    // Driver: serves memory waits per plan and pushes the model's expectation at each new fetch.
    initial begin
        stim_t cur;
        int    fcnt, dcnt, rst_hold;
        bit    in_fetch;
        cur = '{ins: 20'h0, af: 4'h0, fw: 0, mw: 0, rst_mid: 1'b0};
        fcnt = 0; dcnt = 0; in_fetch = 0; rst_hold = 4;
        reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0; mem_ready = 1'b0;
        add_stim(20'hE0821, 4'b0000, 0, 0, 0);  // ADD R1,R2,R3
        add_stim(20'hE2500, 4'b0100, 0, 0, 0);  // SUBS R0,R0,#1 -> Z
        add_stim(20'h0A000, 4'b0000, 0, 0, 0);  // BEQ taken
        add_stim(20'h1A000, 4'b0000, 0, 0, 0);  // BNE not taken
        add_stim(20'hE5954, 4'b0000, 2, 3, 0);  // LDR R4,[R5,#8], 10 cycles
        add_stim(20'hE2922, 4'b0000, 0, 0, 0);  // ADDS clears Z
        add_stim(20'h05854, 4'b0000, 0, 2, 0);  // STREQ fails
        add_stim(20'hE1510, 4'b0110, 0, 0, 0);  // CMP R1,R1
        add_stim(20'hE0113, 4'b1001, 0, 0, 0);  // ANDS -> 1010
        add_stim(20'hEF000, 4'b0000, 1, 0, 0);  // op=11 undefined
        for (int i = 0; i < 150; i++)
            add_stim(rand_ins(), 4'($urandom_range(15, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 0);
        add_stim(20'hE5954, 4'b0000, 0, 6, 1);  // LDR aborted by reset in MEMRD stall
        add_stim(20'hE0821, 4'b0000, 0, 0, 0);
        forever begin
            @(negedge clk);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) begin
                    reset = 1'b0; in_fetch = 0; #1;
                end else begin
                    mem_ready = 1'b0;
                end
            end
            if (rst_hold == 0) begin
                if (mem_req && !AdrSrc) begin
                    if (!in_fetch) begin
                        in_fetch = 1;
                        if (stim_q.size() == 0) begin
                            drv_done = 1'b1;
                        end else begin
                            cur = stim_q.pop_front();
                            Instr = cur.ins; ALUFlags = cur.af;
                            exp_q.push_back(model_instr(cur.ins, cur.af, cur.fw, cur.mw));
                            fcnt = 0; dcnt = 0;
                        end
                    end
                    if (drv_done) begin
                        mem_ready = 1'b0;
                    end else begin
                        mem_ready = (fcnt >= cur.fw); fcnt++;
                    end
                end else begin
                    in_fetch = 0;
                    if (mem_req && AdrSrc) begin
                        if (cur.rst_mid && dcnt == 2) begin
                            reset = 1'b1; rst_hold = 3; mflags = 4'b0000; mem_ready = 1'b0;
                        end else begin
                            mem_ready = (dcnt >= cur.mw); dcnt++;
                        end
                    end else begin
                        mem_ready = 1'($urandom_range(1, 0));
                    end
                end
            end
        end
    end

    // Monitor: splits the output stream into instructions at each fresh fetch and scores them.
    initial begin
        rec_t act, e;
        bit   rec_open, got_dec, prev_stall, prev_reset, was_fetch, is_fetch;
        logic [13:0] vec, prev_vec;
        rec_open = 0; got_dec = 0; prev_stall = 0; prev_reset = 1; was_fetch = 0;
        prev_vec = '0; act = '{default: 0};
        forever begin
            @(negedge clk);
            #3;
            is_fetch = mem_req && !AdrSrc;
            vec = {mem_req, MemWrite, AdrSrc, RegWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Shifted, undef};
            if (reset) begin
                check("reset_strobes", {vec, IRWrite, PCWrite}, 32'd0);
                if (rec_open) begin
                    rec_open = 0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                prev_stall = 0;
            end else begin
                if (prev_reset) check("flags_after_reset", Flags, 4'b0000);
                if (prev_stall) check("stall_stable", vec, prev_vec);
                if (is_fetch && !was_fetch) begin
                    if (rec_open) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL extra_instr (instr %0d): actual 1 record required 0", inst_idx);
                        end else begin
                            e = exp_q.pop_front();
                            act.flags = Flags;
                            check("cycles", act.cycles, e.cycles);
                            check("irwrite_pulses", act.irw, e.irw);
                            check("pcwrite_fetch", act.pcw_fetch, e.pcw_fetch);
                            check("regwrite", act.regw, e.regw);
                            check("pcwrite_late", act.pcw_extra, e.pcw_extra);
                            check("memwrite", act.memw, e.memw);
                            check("data_req", act.dreq, e.dreq);
                            check("undef", act.undefs, e.undefs);
                            check("flags", act.flags, e.flags);
                            check("immsrc", act.imm, e.imm);
                            check("regsrc", act.rsrc, e.rsrc);
                            check("has_exec", act.has_exec, e.has_exec);
                            if (e.has_exec) begin
                                check("alucontrol", act.alu, e.alu);
                                check("shifted", act.shifted, e.shifted);
                            end
                        end
                        inst_idx++;
                    end
                    act = '{default: 0}; rec_open = 1; got_dec = 0;
                end
                if (rec_open) begin
                    act.cycles++;
                    act.irw += int'(IRWrite);
                    if (is_fetch) act.pcw_fetch += int'(PCWrite);
                    else act.pcw_extra += int'(PCWrite);
                    act.regw   += int'(RegWrite);
                    act.memw   += int'(MemWrite);
                    act.dreq   += int'(mem_req && AdrSrc);
                    act.undefs += int'(undef);
                    if (!is_fetch && !got_dec) begin
                        got_dec = 1; act.imm = ImmSrc; act.rsrc = RegSrc;
                    end
                    if (!is_fetch && !ALUSrcA && !act.has_exec) begin
                        act.has_exec = 1; act.alu = ALUControl; act.shifted = Shifted;
                    end
                end
                prev_stall = mem_req && !mem_ready;
            end
            prev_vec = vec; prev_reset = reset; was_fetch = is_fetch && !reset;
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!drv_done && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!drv_done) begin
            errors++;
            $display("FAIL timeout: actual %0d cycles without completion required < 20000", waited);
        end
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
